// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU arbiter: opcodes and FSM states.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit ALU: ADD, OR, SUB, XOR.
// Optional macro ALU_FLAGS_EN adds a carry output (carry-out for ADD, borrow for SUB).
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic [N-1:0] y
`ifdef ALU_FLAGS_EN
    ,
    output logic         carry
`endif
);

`ifdef ALU_FLAGS_EN
    // One extra bit holds carry-out of the add and borrow of the subtract.
    localparam int unsigned W = N + 1;
`else
    localparam int unsigned W = N;
`endif

    logic [W-1:0] sum_w;
    logic [W-1:0] diff_w;

    // Operation select; subtraction wraps modulo 2^N.
    always_comb begin
        sum_w  = W'(a) + W'(b);
        diff_w = W'(a) - W'(b);
        y      = '0;
        case (op)
            OP_ADD:  y = sum_w[N-1:0];
            OP_OR:   y = a | b;
            OP_SUB:  y = diff_w[N-1:0];
            default: y = a ^ b;
        endcase
`ifdef ALU_FLAGS_EN
        carry = 1'b0;
        case (op)
            OP_ADD:  carry = sum_w[N];
            OP_SUB:  carry = diff_w[N];
            default: carry = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU core.
// Grant in IDLE latches the winner's operands; the registered result follows one cycle later.
// Optional macro ALU_FLAGS_EN adds registered zero_flag / carry_flag outputs.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [1:0]   op0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic [1:0]   op1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [N-1:0] result,
    output logic         result_valid,
    output logic         result_id
`ifdef ALU_FLAGS_EN
    ,
    output logic         zero_flag,
    output logic         carry_flag
`endif
);

    state_t       state_q, state_d;
    logic         last_gnt_q, last_gnt_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [1:0]   op_q, op_d;
    logic         id_q, id_d;
    logic         gnt0_q, gnt0_d;
    logic         gnt1_q, gnt1_d;
    logic [N-1:0] result_q, result_d;
    logic         result_valid_q, result_valid_d;
    logic         result_id_q, result_id_d;
    logic         pick;
    logic [N-1:0] alu_y;
`ifdef ALU_FLAGS_EN
    logic         alu_carry;
    logic         zero_q, zero_d;
    logic         carry_q, carry_d;
`endif

    alu_core #(.N(N)) u_alu_core (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .y     (alu_y)
`ifdef ALU_FLAGS_EN
        ,
        .carry (alu_carry)
`endif
    );

    // Arbitration, operand capture and result update; pulses default low.
    always_comb begin
        state_d        = state_q;
        last_gnt_d     = last_gnt_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        id_d           = id_q;
        gnt0_d         = 1'b0;
        gnt1_d         = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        result_id_d    = result_id_q;
        pick           = 1'b0;
`ifdef ALU_FLAGS_EN
        zero_d         = zero_q;
        carry_d        = carry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to whoever was not granted last.
                    pick       = (req0 && req1) ? ~last_gnt_q : req1;
                    id_d       = pick;
                    a_d        = pick ? a1  : a0;
                    b_d        = pick ? b1  : b0;
                    op_d       = pick ? op1 : op0;
                    gnt0_d     = ~pick;
                    gnt1_d     = pick;
                    last_gnt_d = pick;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                result_d       = alu_y;
                result_valid_d = 1'b1;
                result_id_d    = id_q;
`ifdef ALU_FLAGS_EN
                zero_d         = (alu_y == '0);
                carry_d        = alu_carry;
`endif
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_gnt_q     <= 1'b1;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            id_q           <= 1'b0;
            gnt0_q         <= 1'b0;
            gnt1_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
            zero_q         <= 1'b0;
            carry_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            last_gnt_q     <= last_gnt_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            id_q           <= id_d;
            gnt0_q         <= gnt0_d;
            gnt1_q         <= gnt1_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
`ifdef ALU_FLAGS_EN
            zero_q         <= zero_d;
            carry_q        <= carry_d;
`endif
        end
    end

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
`ifdef ALU_FLAGS_EN
    assign zero_flag    = zero_q;
    assign carry_flag   = carry_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: stimulus pushes expected results, a monitor pops them.
module tb_alu_rr_arbiter;
    import alu_pkg::*;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]   op0 = '0, op1 = '0;
    logic         gnt0, gnt1, result_valid, result_id;
    logic [N-1:0] result;
`ifdef ALU_FLAGS_EN
    logic         zero_flag, carry_flag;
`endif

    typedef struct packed {
        logic         id;
        logic [N-1:0] res;
        logic         z;
        logic         c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_rr_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .a0           (a0),
        .b0           (b0),
        .op0          (op0),
        .req1         (req1),
        .a1           (a1),
        .b1           (b1),
        .op1          (op1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .result       (result),
        .result_valid (result_valid),
        .result_id    (result_id)
`ifdef ALU_FLAGS_EN
        ,
        .zero_flag    (zero_flag),
        .carry_flag   (carry_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [N-1:0] res, input logic z, input logic c);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.z   = z;
        e.c   = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string name, input logic g0, input logic g1);
        chk({name, "_gnt0"}, gnt0, g0);
        chk({name, "_gnt1"}, gnt1, g1);
    endtask

    // Monitor: every result_valid pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (gnt0 || gnt1)
                chk("gnt_onehot", gnt0 & gnt1, 0);
            if (result_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result_valid: got 1 expected 0 (result=%0h id=%0d)",
                             result, result_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("result_id", result_id, e.id);
`ifdef ALU_FLAGS_EN
                    chk("zero_flag", zero_flag, e.z);
                    chk("carry_flag", carry_flag, e.c);
`endif
                end
            end
        end
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

`ifdef ALU_FLAGS_EN
    task automatic single0(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op,
                           input logic [N-1:0] res, input logic z, input logic c);
        req0 = 1'b1; a0 = a; b0 = b; op0 = op;
        push(1'b0, res, z, c);
        tick();
        chk_gnt("flags_grant", 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        tick();
    endtask
`endif

    initial begin
        // Reset for two edges
        tick();
        tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_id", result_id, 0);
        rst = 1'b0;

        // Single request from requester 0: 9+8 wraps to 1
        req0 = 1'b1; a0 = 4'h9; b0 = 4'h8; op0 = OP_ADD;
        push(1'b0, 4'h1, 1'b0, 1'b1);
        tick();
        chk_gnt("single0", 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        chk_gnt("single0_busy", 1'b0, 1'b0);
        tick();

        // Contention right after reset: requester 0 first, then 1, then 0 again
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1'b1; a0 = 4'h3; b0 = 4'h5; op0 = OP_SUB;
        req1 = 1'b1; a1 = 4'hC; b1 = 4'hA; op1 = OP_XOR;
        push(1'b0, 4'hE, 1'b0, 1'b1);
        push(1'b1, 4'h6, 1'b0, 1'b0);
        tick();
        chk_gnt("contend_a", 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        chk_gnt("contend_a_busy", 1'b0, 1'b0);
        tick();
        chk_gnt("contend_b", 1'b0, 1'b1);
        req0 = 1'b1; a0 = 4'h1; b0 = 4'h2; op0 = OP_ADD;
        a1 = 4'h5; b1 = 4'h9; op1 = OP_OR;
        push(1'b0, 4'h3, 1'b0, 1'b0);
        push(1'b1, 4'hD, 1'b0, 1'b0);
        tick();
        chk_gnt("contend_b_busy", 1'b0, 1'b0);
        tick();
        chk_gnt("contend_c", 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        tick();
        chk_gnt("contend_d", 1'b0, 1'b1);
        req1 = 1'b0;
        tick();
        tick();

        // req1 held for six edges; operands changed after each grant
        req1 = 1'b1; a1 = 4'h6; b1 = 4'h3; op1 = OP_ADD;
        push(1'b1, 4'h9, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_gnt("held_req1", 1'b0, (i % 2) == 0);
            if (i == 0) begin
                a1 = 4'h1;
                push(1'b1, 4'h4, 1'b0, 1'b0);
            end
            if (i == 2) begin
                a1 = 4'hF;
                push(1'b1, 4'h2, 1'b0, 1'b1);
            end
        end
        req1 = 1'b0;
        tick();

        // Reset while BUSY discards the in-flight operation
        req0 = 1'b1; a0 = 4'h1; b0 = 4'h1; op0 = OP_ADD;
        tick();
        chk_gnt("busy_rst_grant", 1'b1, 1'b0);
        req0 = 1'b0;
        rst = 1'b1;
        tick();
        chk("busy_rst_result_valid", result_valid, 0);
        chk("busy_rst_gnt0", gnt0, 0);
        chk("busy_rst_result", result, 0);
        chk("busy_rst_result_id", result_id, 0);
        rst = 1'b0;
        tick();
        chk("busy_rst_no_pulse", result_valid, 0);

        // Round-robin pointer restored by reset: contention grants 0
        req0 = 1'b1; a0 = 4'h8; b0 = 4'h8; op0 = OP_SUB;
        req1 = 1'b1; a1 = 4'h2; b1 = 4'h1; op1 = OP_OR;
        push(1'b0, 4'h0, 1'b1, 1'b0);
        push(1'b1, 4'h3, 1'b0, 1'b0);
        tick();
        chk_gnt("post_rst_contend", 1'b1, 1'b0);
        req0 = 1'b0;
        tick();
        tick();
        chk_gnt("post_rst_second", 1'b0, 1'b1);
        req1 = 1'b0;
        tick();
        tick();

`ifdef ALU_FLAGS_EN
        single0(4'hF, 4'h1, OP_ADD, 4'h0, 1'b1, 1'b1);
        single0(4'h2, 4'h3, OP_SUB, 4'hF, 1'b0, 1'b1);
        single0(4'hF, 4'hF, OP_OR,  4'hF, 1'b0, 1'b0);
        single0(4'h5, 4'h2, OP_SUB, 4'h3, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
